// File: rtl/top_scpu_iobus_app_pkg.sv
// Shared constants for the single-cycle MIPS board top: I/O map, VGA timing,
// MIPS opcodes and the 7-segment glyph table.
package top_scpu_iobus_app_pkg;

    localparam logic [31:0] ColorAddr = 32'hC000_0000;
    localparam logic [31:0] Ps2Addr   = 32'hD000_0000;
    localparam logic [31:0] SegAddr   = 32'hE000_0000;
    localparam logic [31:0] IoAddr    = 32'hF000_0000;

    localparam logic [9:0] HVisible   = 10'd640;
    localparam logic [9:0] HSyncStart = 10'd656;
    localparam logic [9:0] HSyncEnd   = 10'd752;
    localparam logic [9:0] HTotal     = 10'd800;
    localparam logic [9:0] VVisible   = 10'd480;
    localparam logic [9:0] VSyncStart = 10'd490;
    localparam logic [9:0] VSyncEnd   = 10'd492;
    localparam logic [9:0] VTotal     = 10'd525;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnSlt  = 6'h2A;

    // Active-low {dp,g,f,e,d,c,b,a}; dp always off.
    function automatic logic [7:0] seg_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/dmem.sv
// Word-addressed data RAM: synchronous write, combinational read.
module dmem #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/imem.sv
// Instruction ROM holding the board bring-up program.
module imem (
    input  logic [5:0]  addr,
    output logic [31:0] inst
);

    // Program: LED<=A5, LED<=switches, seg<=1234, color<=5, then poll PS/2:
    // each byte goes to LED, a re-read of status flags EE if ready stuck,
    // and a received-byte count goes to seg.
    always_comb begin
        case (addr)
            6'd0:  inst = 32'h3C01_F000; // lui   $1, 0xF000
            6'd1:  inst = 32'h3402_00A5; // ori   $2, $0, 0xA5
            6'd2:  inst = 32'hAC22_0000; // sw    $2, 0($1)
            6'd3:  inst = 32'h8C23_0000; // lw    $3, 0($1)
            6'd4:  inst = 32'hAC23_0000; // sw    $3, 0($1)
            6'd5:  inst = 32'h3C04_E000; // lui   $4, 0xE000
            6'd6:  inst = 32'h3405_1234; // ori   $5, $0, 0x1234
            6'd7:  inst = 32'hAC85_0000; // sw    $5, 0($4)
            6'd8:  inst = 32'h3C06_C000; // lui   $6, 0xC000
            6'd9:  inst = 32'h3407_0005; // ori   $7, $0, 5
            6'd10: inst = 32'hACC7_0000; // sw    $7, 0($6)
            6'd11: inst = 32'h3C08_D000; // lui   $8, 0xD000
            6'd12: inst = 32'h340A_0000; // ori   $10, $0, 0
            6'd13: inst = 32'h8C2B_0000; // loop: lw $11, 0($1)
            6'd14: inst = 32'h316C_0800; // andi  $12, $11, 0x800
            6'd15: inst = 32'h1180_FFFD; // beq   $12, $0, loop
            6'd16: inst = 32'h8D0D_0000; // lw    $13, 0($8)
            6'd17: inst = 32'hAC2D_0000; // sw    $13, 0($1)
            6'd18: inst = 32'h8C2B_0000; // lw    $11, 0($1)
            6'd19: inst = 32'h316C_0800; // andi  $12, $11, 0x800
            6'd20: inst = 32'h1180_0002; // beq   $12, $0, skip
            6'd21: inst = 32'h340E_00EE; // ori   $14, $0, 0xEE
            6'd22: inst = 32'hAC2E_0000; // sw    $14, 0($1)
            6'd23: inst = 32'h254A_0001; // skip: addiu $10, $10, 1
            6'd24: inst = 32'hAC8A_0000; // sw    $10, 0($4)
            6'd25: inst = 32'h0800_000D; // j     loop
            default: inst = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/scpu_core.sv
// Single-cycle MIPS subset core; state advances only on ce.
module scpu_core
    import top_scpu_iobus_app_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] inst,
    input  logic [31:0] data_in,
    output logic [31:0] pc,
    output logic [31:0] addr,
    output logic [31:0] data_out,
    output logic        mem_w
);

    logic [31:0] regs [32];
    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wr_reg;
    logic [31:0] imm_s, imm_z, rs_val, rt_val, alu, wb_val;
    logic        reg_we, is_lw, is_sw;

    assign op       = inst[31:26];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign rd       = inst[15:11];
    assign funct    = inst[5:0];
    assign imm_s    = {{16{inst[15]}}, inst[15:0]};
    assign imm_z    = {16'b0, inst[15:0]};
    assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign pc_plus4 = pc_q + 32'd4;

    logic unused_shamt;
    assign unused_shamt = ^inst[10:6];

    always_comb begin
        alu    = '0;
        reg_we = 1'b0;
        wr_reg = rt;
        is_lw  = 1'b0;
        is_sw  = 1'b0;
        pc_d   = pc_plus4;
        case (op)
            OpRtype: begin
                wr_reg = rd;
                reg_we = 1'b1;
                case (funct)
                    FnAddu:  alu = rs_val + rt_val;
                    FnSubu:  alu = rs_val - rt_val;
                    FnAnd:   alu = rs_val & rt_val;
                    FnOr:    alu = rs_val | rt_val;
                    FnSlt:   alu = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    default: reg_we = 1'b0;
                endcase
            end
            OpAddiu: begin alu = rs_val + imm_s; reg_we = 1'b1; end
            OpAndi:  begin alu = rs_val & imm_z; reg_we = 1'b1; end
            OpOri:   begin alu = rs_val | imm_z; reg_we = 1'b1; end
            OpLui:   begin alu = {inst[15:0], 16'b0}; reg_we = 1'b1; end
            OpLw:    begin alu = rs_val + imm_s; reg_we = 1'b1; is_lw = 1'b1; end
            OpSw:    begin alu = rs_val + imm_s; is_sw = 1'b1; end
            OpBeq:   if (rs_val == rt_val) pc_d = pc_plus4 + {imm_s[29:0], 2'b00};
            OpBne:   if (rs_val != rt_val) pc_d = pc_plus4 + {imm_s[29:0], 2'b00};
            OpJ:     pc_d = {pc_plus4[31:28], inst[25:0], 2'b00};
            default: ;
        endcase
    end

    assign wb_val = is_lw ? data_in : alu;

    // Bus address only shows during loads/stores so ALU ops never alias I/O reads.
    assign addr     = (is_lw || is_sw) ? alu : 32'd0;
    assign data_out = rt_val;
    assign mem_w    = is_sw;
    assign pc       = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (ce) begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ce && reg_we && wr_reg != 5'd0) begin
            regs[wr_reg] <= wb_val;
        end
    end

endmodule

// File: rtl/vga_sync.sv
// 640x480 timing counters advancing on ce; hs/vs active-low, combinational from counters.
module vga_sync
    import top_scpu_iobus_app_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ce,
    output logic hs,
    output logic vs,
    output logic active
);

    logic [9:0] hcnt_q, vcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (ce) begin
            if (hcnt_q == HTotal - 10'd1) begin
                hcnt_q <= '0;
                vcnt_q <= (vcnt_q == VTotal - 10'd1) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_q <= hcnt_q + 10'd1;
            end
        end
    end

    assign hs     = ~(hcnt_q >= HSyncStart && hcnt_q < HSyncEnd);
    assign vs     = ~(vcnt_q >= VSyncStart && vcnt_q < VSyncEnd);
    assign active = (hcnt_q < HVisible) && (vcnt_q < VVisible);

endmodule

// File: rtl/top_scpu_iobus_app.sv
// Board top: CPU + memories, I/O bus decode, LEDs, 7-seg scan, PS/2 receiver, VGA.
module top_scpu_iobus_app
    import top_scpu_iobus_app_pkg::*;
#(
    parameter int unsigned SCAN_BITS = 16,
    parameter int unsigned DMEM_AW   = 10
) (
    input  logic       clk_50mhz,
    input  logic [3:0] BTN,
    input  logic [7:0] SW,
    input  logic       PS2_clk,
    input  logic       PS2_Data,
    output logic [7:0] SEGMENT,
    output logic [3:0] AN,
    output logic [7:0] LED,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [2:0] vga_rgb
);

    logic clk;
    assign clk = clk_50mhz;

    // Button sync carries the reset itself, so it cannot be reset.
    logic [3:0] btn_m, btn_s;
    always_ff @(posedge clk) begin
        btn_m <= BTN;
        btn_s <= btn_m;
    end

    logic rst;
    assign rst = btn_s[3];

    logic [7:0] sw_m, sw_s;
    logic       ps2c_m, ps2c_s, ps2c_prev, ps2d_m, ps2d_s;
    logic       ce25;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_m      <= '0;
            sw_s      <= '0;
            ps2c_m    <= 1'b1;
            ps2c_s    <= 1'b1;
            ps2c_prev <= 1'b1;
            ps2d_m    <= 1'b1;
            ps2d_s    <= 1'b1;
            ce25      <= 1'b0;
        end else begin
            sw_m      <= SW;
            sw_s      <= sw_m;
            ps2c_m    <= PS2_clk;
            ps2c_s    <= ps2c_m;
            ps2c_prev <= ps2c_s;
            ps2d_m    <= PS2_Data;
            ps2d_s    <= ps2d_m;
            ce25      <= ~ce25;
        end
    end

    // CPU and memories
    logic [31:0] pc, inst, addr, data_out, rdata, dmem_rdata;
    logic        mem_w, bus_we, dmem_sel;

    scpu_core u_core (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce25),
        .inst     (inst),
        .data_in  (rdata),
        .pc       (pc),
        .addr     (addr),
        .data_out (data_out),
        .mem_w    (mem_w)
    );

    imem u_imem (
        .addr (pc[7:2]),
        .inst (inst)
    );

    logic unused_pc;
    assign unused_pc = ^{pc[31:8], pc[1:0]};

    assign bus_we   = ce25 && mem_w;
    assign dmem_sel = (addr[31:28] == 4'h0);

    dmem #(
        .AW (DMEM_AW)
    ) u_dmem (
        .clk   (clk),
        .we    (bus_we && dmem_sel),
        .addr  (addr[DMEM_AW+1:2]),
        .wdata (data_out),
        .rdata (dmem_rdata)
    );

    // Peripheral registers
    logic [7:0]  led_q, ps2_byte_q;
    logic [15:0] seg_q;
    logic [2:0]  color_q;
    logic        ready_q, ovf_q;

    always_comb begin
        rdata = '0;
        if (dmem_sel)              rdata = dmem_rdata;
        else if (addr == Ps2Addr)  rdata = {24'b0, ps2_byte_q};
        else if (addr == SegAddr)  rdata = {16'b0, seg_q};
        else if (addr == IoAddr)   rdata = {19'b0, ovf_q, ready_q, btn_s[2:0], sw_s};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= '0;
            seg_q   <= '0;
            color_q <= '0;
        end else if (bus_we) begin
            if (addr == IoAddr)    led_q   <= data_out[7:0];
            if (addr == SegAddr)   seg_q   <= data_out[15:0];
            if (addr == ColorAddr) color_q <= data_out[2:0];
        end
    end

    // PS/2 receiver: 11-bit frame shifted in LSB first on synced falling edges
    logic [9:0]  frame_q;
    logic [10:0] frame_full;
    logic [3:0]  bit_cnt_q;
    logic [19:0] idle_cnt_q;
    logic        ps2_fall, frame_done, frame_ok, ps2_rd;

    assign ps2_fall   = ps2c_prev && !ps2c_s;
    assign frame_full = {ps2d_s, frame_q};
    assign frame_done = ps2_fall && (bit_cnt_q == 4'd10);
    assign frame_ok   = frame_done && !frame_full[0] && frame_full[10] && (^frame_full[9:1]);
    assign ps2_rd     = ce25 && !mem_w && (addr == Ps2Addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
        end else if (ps2_fall) begin
            frame_q    <= {ps2d_s, frame_q[9:1]};
            bit_cnt_q  <= frame_done ? 4'd0 : bit_cnt_q + 4'd1;
            idle_cnt_q <= '0;
        end else if (bit_cnt_q != 4'd0) begin
            if (idle_cnt_q == '1) begin
                bit_cnt_q  <= '0;
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + 20'd1;
            end
        end
    end

    // A completing frame beats a simultaneous clearing read.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_byte_q <= '0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (frame_ok) begin
            ps2_byte_q <= frame_full[8:1];
            ready_q    <= 1'b1;
            ovf_q      <= (ovf_q || ready_q) && !ps2_rd;
        end else if (ps2_rd) begin
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
        end
    end

    // 7-segment scan
    logic [SCAN_BITS+1:0] scan_cnt_q;
    logic [1:0]           digit;
    logic [3:0]           an_q;
    logic [7:0]           segment_q;

    assign digit = scan_cnt_q[SCAN_BITS+1:SCAN_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            an_q       <= 4'hF;
            segment_q  <= 8'hFF;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
            an_q       <= ~(4'b0001 << digit);
            segment_q  <= seg_glyph(seg_q[{digit, 2'b00} +: 4]);
        end
    end

    // VGA
    logic hs_raw, vs_raw, active;
    logic hs_q, vs_q;
    logic [2:0] rgb_q;

    vga_sync u_vga_sync (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce25),
        .hs     (hs_raw),
        .vs     (vs_raw),
        .active (active)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= '0;
        end else begin
            hs_q  <= hs_raw;
            vs_q  <= vs_raw;
            rgb_q <= active ? color_q : 3'b000;
        end
    end

    assign LED     = led_q;
    assign AN      = an_q;
    assign SEGMENT = segment_q;
    assign vga_hs  = hs_q;
    assign vga_vs  = vs_q;
    assign vga_rgb = rgb_q;

endmodule

// File: tb/tb_top_scpu_iobus_app.sv
// Directed bench for the board top, driven by the built-in imem program.
module tb_top_scpu_iobus_app;

    logic       clk;
    logic [3:0] btn;
    logic [7:0] sw;
    logic       ps2_clk, ps2_data;
    logic [7:0] segment, led;
    logic [3:0] an;
    logic       vga_hs, vga_vs;
    logic [2:0] vga_rgb;

    int n_cmp = 0;
    int n_err = 0;

    top_scpu_iobus_app #(
        .SCAN_BITS (3),
        .DMEM_AW   (10)
    ) dut (
        .clk_50mhz (clk),
        .BTN       (btn),
        .SW        (sw),
        .PS2_clk   (ps2_clk),
        .PS2_Data  (ps2_data),
        .SEGMENT   (segment),
        .AN        (an),
        .LED       (led),
        .vga_hs    (vga_hs),
        .vga_vs    (vga_vs),
        .vga_rgb   (vga_rgb)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_led(input logic [7:0] from, input int budget);
        for (int i = 0; i < budget && led == from; i++) @(negedge clk);
    endtask

    task automatic scan_check(input string tag, input logic [3:0] an_exp,
                              input logic [7:0] seg_exp);
        for (int i = 0; i < 100 && an != an_exp; i++) @(negedge clk);
        check({tag, "_an"}, an, an_exp);
        check(tag, segment, seg_exp);
    endtask

    task automatic send_ps2(input logic [7:0] data, input logic bad_parity);
        logic [10:0] f;
        f = {1'b1, (~^data) ^ bad_parity, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            repeat (8) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (8) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    int hs_low, rgb_on, rgb_blank, vs_low, period;
    logic prev_hs;

    initial begin
        btn      = 4'b1000;
        sw       = 8'h3C;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_led", led, 8'h00);
        check("rst_an", an, 4'hF);
        check("rst_segment", segment, 8'hFF);
        check("rst_hs", vga_hs, 1'b1);
        check("rst_vs", vga_vs, 1'b1);
        check("rst_rgb", vga_rgb, 3'b000);
        btn = 4'b0000;

        for (int i = 0; i < 10 && dut.rst; i++) @(negedge clk);
        check("first_pc", dut.pc, 32'h0);
        repeat (2) @(negedge clk);
        check("second_pc", dut.pc, 32'h4);

        wait_led(8'h00, 100);
        check("led_const", led, 8'hA5);
        wait_led(8'hA5, 100);
        check("led_switches", led, 8'h3C);

        repeat (20) @(negedge clk);
        scan_check("digit0_4", 4'b1110, 8'h99);
        scan_check("digit1_3", 4'b1101, 8'hB0);
        scan_check("digit2_2", 4'b1011, 8'hA4);
        scan_check("digit3_1", 4'b0111, 8'hF9);

        // One full line window: 96 sync and 640 visible pixels at two clocks each
        hs_low = 0; rgb_on = 0; rgb_blank = 0; vs_low = 0;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            if (!vga_hs) hs_low++;
            if (!vga_vs) vs_low++;
            if (vga_rgb == 3'b101) rgb_on++;
            if (!vga_hs && vga_rgb != 3'b000) rgb_blank++;
        end
        check("hs_low_clocks", hs_low, 192);
        check("rgb_visible_clocks", rgb_on, 1280);
        check("rgb_in_blank", rgb_blank, 0);
        check("vs_low_early_lines", vs_low, 0);

        prev_hs = vga_hs;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            if (prev_hs && !vga_hs) break;
            prev_hs = vga_hs;
        end
        period = 0;
        prev_hs = vga_hs;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            period++;
            if (prev_hs && !vga_hs) break;
            prev_hs = vga_hs;
        end
        check("hs_period", period, 1600);

        send_ps2(8'h1C, 1'b0);
        wait_led(8'h3C, 400);
        check("ps2_byte_1c", led, 8'h1C);
        repeat (100) @(negedge clk);
        check("ps2_ready_cleared", led, 8'h1C);
        scan_check("count_after_good", 4'b1110, 8'hF9);

        send_ps2(8'h1C, 1'b1);
        repeat (200) @(negedge clk);
        check("bad_parity_led", led, 8'h1C);
        scan_check("count_after_bad", 4'b1110, 8'hF9);

        send_ps2(8'h5A, 1'b0);
        wait_led(8'h1C, 400);
        check("ps2_byte_5a", led, 8'h5A);
        repeat (40) @(negedge clk);
        scan_check("count_after_second", 4'b1110, 8'hA4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
